// File: rtl/mem_rr_arbiter.sv
// N-to-1 pipelined memory request arbiter with in-order response routing (MEM_ARB_ROUND_ROBIN_EN: round-robin, else fixed priority).
// Latency: grant and response routing are combinational; ID FIFO, pointer and lock update on the next edge.
// Backpressure: a stalled request locks the winner until granted; no request while MAX_OUTSTANDING IDs are in flight.

module mem_rr_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdat_i,
    output logic [W-1:0] rdat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic [CW-1:0] r_cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rptr <= '0;
            r_wptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (push_i) r_wptr <= ptr_inc(r_wptr);
            if (pop_i)  r_rptr <= ptr_inc(r_rptr);
            if (push_i && !pop_i)      r_cnt <= r_cnt + CW'(1);
            else if (pop_i && !push_i) r_cnt <= r_cnt - CW'(1);
        end
    end

    // Storage needs no reset: entries are only read while the count covers them.
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wptr] <= wdat_i;
    end

    assign rdat_o  = r_mem[r_rptr];
    assign full_o  = (r_cnt == CW'(DEPTH));
    assign empty_o = (r_cnt == '0);
endmodule

module mem_rr_arbiter #(
    parameter int NR_PORTS        = 3,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4,
    localparam int IDW            = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1,
    localparam int BW             = DATA_WIDTH / 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NR_PORTS-1:0]            data_req_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0] address_i,
    input  logic [NR_PORTS*DATA_WIDTH-1:0] data_wdata_i,
    input  logic [NR_PORTS-1:0]            data_we_i,
    input  logic [NR_PORTS*BW-1:0]         data_be_i,
    input  logic [NR_PORTS*2-1:0]          data_size_i,
    output logic [NR_PORTS-1:0]            data_gnt_o,
    output logic [NR_PORTS-1:0]            data_rvalid_o,
    output logic [NR_PORTS*DATA_WIDTH-1:0] data_rdata_o,
    output logic                           data_req_o,
    output logic [ADDR_WIDTH-1:0]          address_o,
    output logic [DATA_WIDTH-1:0]          data_wdata_o,
    output logic                           data_we_o,
    output logic [BW-1:0]                  data_be_o,
    output logic [1:0]                     data_size_o,
    output logic [IDW-1:0]                 id_o,
    input  logic                           data_gnt_i,
    input  logic                           data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]          data_rdata_i,
    output logic                           err_o
);
    localparam int SW = IDW + 1;

    logic           r_lock_vld;
    logic [IDW-1:0] r_lock_id;
    logic           r_err;
    logic           w_full;
    logic           w_empty;
    logic           w_found;
    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_sel;
    logic [IDW-1:0] w_head;
    logic [IDW-1:0] w_cand;
    logic           w_push;
    logic           w_pop;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] r_rr_ptr;
    logic [SW-1:0]  w_sum;
`endif

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w_sum   = '0;
`endif
        if (!w_full) begin
            if (r_lock_vld) begin
                // A dropped locked request leaves no winner this cycle rather than switching ports.
                w_found = data_req_i[r_lock_id];
                w_win   = r_lock_id;
            end else begin
                for (int i = 0; i < NR_PORTS; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    w_sum = {1'b0, r_rr_ptr} + SW'(i);
                    if (w_sum >= SW'(NR_PORTS)) w_sum = w_sum - SW'(NR_PORTS);
                    w_cand = w_sum[IDW-1:0];
`else
                    w_cand = IDW'(i);
`endif
                    if (!w_found && data_req_i[w_cand]) begin
                        w_found = 1'b1;
                        w_win   = w_cand;
                    end
                end
            end
        end
    end

    assign w_sel  = w_found ? w_win : (r_lock_vld ? r_lock_id : '0);
    assign w_push = w_found & data_gnt_i;
    assign w_pop  = data_rvalid_i & ~w_empty;

    assign data_req_o   = w_found;
    assign id_o         = w_sel;
    assign address_o    = address_i[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_wdata_o = data_wdata_i[w_sel*DATA_WIDTH +: DATA_WIDTH];
    assign data_we_o    = data_we_i[w_sel];
    assign data_be_o    = data_be_i[w_sel*BW +: BW];
    assign data_size_o  = data_size_i[w_sel*2 +: 2];
    assign data_gnt_o   = w_push ? (NR_PORTS'(1) << w_win) : '0;
    assign data_rvalid_o = w_pop ? (NR_PORTS'(1) << w_head) : '0;
    assign err_o        = r_err;

    always_comb begin
        data_rdata_o = '0;
        if (w_pop) data_rdata_o[w_head*DATA_WIDTH +: DATA_WIDTH] = data_rdata_i;
    end

    mem_rr_fifo #(
        .W     (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdat_i  (w_win),
        .rdat_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock_vld <= 1'b0;
            r_lock_id  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_lock_vld <= w_found & ~data_gnt_i;
            if (w_found) r_lock_id <= w_win;
            if (data_rvalid_i && w_empty) r_err <= 1'b1;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
        end else if (w_push) begin
            r_rr_ptr <= (w_win == IDW'(NR_PORTS - 1)) ? '0 : w_win + IDW'(1);
        end
    end
`endif
endmodule
